// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - RISC-V major opcodes and funct7 classes
//   - 5-bit ALU operation codes (ADD=00000 ... MULHU=10110)
//   - ctrl_t, the packed control bundle handed to execute, and CTRL_W
//   - buf_state_e, the skid-buffer occupancy state
//   - helpers mapping funct3 to ALU codes for register and immediate forms
package decode_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [11:0] SYS_ECALL  = 12'h000;
  localparam logic [11:0] SYS_EBREAK = 12'h001;
  localparam logic [11:0] SYS_MRET   = 12'h302;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_ADDI   = 5'd10;
  localparam logic [4:0] ALU_SLTI   = 5'd11;
  localparam logic [4:0] ALU_SLTIU  = 5'd12;
  localparam logic [4:0] ALU_XORI   = 5'd13;
  localparam logic [4:0] ALU_ORI    = 5'd14;
  localparam logic [4:0] ALU_ANDI   = 5'd15;
  localparam logic [4:0] ALU_SLLI   = 5'd16;
  localparam logic [4:0] ALU_SRLI   = 5'd17;
  localparam logic [4:0] ALU_SRAI   = 5'd18;
  localparam logic [4:0] ALU_MUL    = 5'd19;
  localparam logic [4:0] ALU_MULH   = 5'd20;
  localparam logic [4:0] ALU_MULHSU = 5'd21;
  localparam logic [4:0] ALU_MULHU  = 5'd22;

  typedef struct packed {
    logic        reg_write;
    logic        alu_src;
    logic        is_branch;
    logic [2:0]  b_type;
    logic        jal;
    logic        jalr;
    logic        is_load;
    logic        is_store;
    logic [2:0]  mem_size;
    logic        is_lui;
    logic        is_auipc;
    logic        is_div;
    logic [2:0]  div_op;
    logic        csr_we;
    logic [2:0]  csr_func;
    logic [11:0] csr_addr;
    logic        is_ecall;
    logic        is_ebreak;
    logic        is_mret;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  function automatic logic [4:0] alu_reg_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // SRAI shares funct3=101 with SRLI; the caller picks SRAI from funct7.
  function automatic logic [4:0] alu_imm_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADDI;
      3'b001:  return ALU_SLLI;
      3'b010:  return ALU_SLTI;
      3'b011:  return ALU_SLTIU;
      3'b100:  return ALU_XORI;
      3'b101:  return ALU_SRLI;
      3'b110:  return ALU_ORI;
      default: return ALU_ANDI;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I/RV64I (+M, +Zicsr) instruction decoder.
// Ports:
//   instr               in  32    raw instruction
//   rd/rs1/rs2          out 5     register indices, 0 when the format does not use them
//   rs1_used/rs2_used   out 1     operand is actually read
//   imm                 out XLEN  sign-extended immediate; zero-extended uimm for CSR*I
//   alu_op              out 5     ALU operation code
//   ctrl                out       control bundle (all zero when illegal)
//   illegal             out 1     instruction is not legal in this configuration
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ENABLE_M   = 1,
  parameter int ENABLE_CSR = 1
) (
  input  logic [31:0]     instr,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            rs1_used,
  output logic            rs2_used,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      alu_op,
  output ctrl_t           ctrl,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
  logic            shamt_hi_bad;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_z = XLEN'(instr[19:15]);

  // On RV32 shamt is 5 bits, so instr[25] must be clear for shift-immediates.
  assign shamt_hi_bad = (XLEN == 32) && instr[25];

  always_comb begin
    rd       = '0;
    rs1      = '0;
    rs2      = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    imm      = '0;
    alu_op   = ALU_ADD;
    ctrl     = '0;
    illegal  = 1'b0;

    case (opcode)
      OPC_OP: begin
        rd = instr[11:7]; rs1 = instr[19:15]; rs2 = instr[24:20];
        rs1_used = 1'b1; rs2_used = 1'b1;
        ctrl.reg_write = 1'b1;
        case (f7)
          F7_BASE: alu_op = alu_reg_op(f3);
          F7_ALT: begin
            if (f3 == 3'b000)      alu_op = ALU_SUB;
            else if (f3 == 3'b101) alu_op = ALU_SRA;
            else                   illegal = 1'b1;
          end
          F7_MULDIV: begin
            if (ENABLE_M == 0) begin
              illegal = 1'b1;
            end else if (f3[2]) begin
              // Divider is a separate unit; the ALU sees ADD and ignores it.
              ctrl.is_div = 1'b1;
              ctrl.div_op = {1'b1, f3[1:0]};
            end else begin
              alu_op = ALU_MUL + 5'(f3[1:0]);
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        rd = instr[11:7]; rs1 = instr[19:15]; rs1_used = 1'b1;
        imm = imm_i;
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
        alu_op = alu_imm_op(f3);
        if (f3 == 3'b001) begin
          if (f7[6:1] != 6'b000000 || shamt_hi_bad) illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          if (f7[6:1] == 6'b010000) alu_op = ALU_SRAI;
          else if (f7[6:1] != 6'b000000) illegal = 1'b1;
          if (shamt_hi_bad) illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        rd = instr[11:7]; rs1 = instr[19:15]; rs1_used = 1'b1;
        imm = imm_i;
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.is_load = 1'b1;
        ctrl.mem_size = f3;
        if (f3 == 3'b111 || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110))) illegal = 1'b1;
      end
      OPC_STORE: begin
        rs1 = instr[19:15]; rs2 = instr[24:20];
        rs1_used = 1'b1; rs2_used = 1'b1;
        imm = imm_s;
        ctrl.alu_src = 1'b1; ctrl.is_store = 1'b1; ctrl.mem_size = f3;
        if (f3[2] || (XLEN == 32 && f3 == 3'b011)) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        rs1 = instr[19:15]; rs2 = instr[24:20];
        rs1_used = 1'b1; rs2_used = 1'b1;
        imm = imm_b;
        ctrl.is_branch = 1'b1; ctrl.b_type = f3;
        if (f3[2:1] == 2'b01) illegal = 1'b1;
      end
      OPC_JAL: begin
        rd = instr[11:7];
        imm = imm_j;
        ctrl.reg_write = 1'b1; ctrl.jal = 1'b1;
      end
      OPC_JALR: begin
        rd = instr[11:7]; rs1 = instr[19:15]; rs1_used = 1'b1;
        imm = imm_i;
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.jalr = 1'b1;
        if (f3 != 3'b000) illegal = 1'b1;
      end
      OPC_LUI: begin
        rd = instr[11:7]; imm = imm_u;
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.is_lui = 1'b1;
      end
      OPC_AUIPC: begin
        rd = instr[11:7]; imm = imm_u;
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.is_auipc = 1'b1;
      end
      OPC_MISC_MEM: begin
        // FENCE/FENCE.I: in-order single-issue core, nothing to do.
      end
      OPC_SYSTEM: begin
        if (f3 == 3'b000) begin
          case (instr[31:20])
            SYS_ECALL:  ctrl.is_ecall  = 1'b1;
            SYS_EBREAK: ctrl.is_ebreak = 1'b1;
            SYS_MRET:   ctrl.is_mret   = 1'b1;
            default:    illegal = 1'b1;
          endcase
        end else if (f3 == 3'b100 || ENABLE_CSR == 0) begin
          illegal = 1'b1;
        end else begin
          rd = instr[11:7];
          ctrl.reg_write = 1'b1;
          ctrl.csr_func  = f3;
          ctrl.csr_addr  = instr[31:20];
          // CSRRS/CSRRC with a zero source are pure reads and must not write.
          ctrl.csr_we    = (f3[1:0] == 2'b01) || (instr[19:15] != 5'd0);
          if (f3[2]) begin
            imm = imm_z;
          end else begin
            rs1 = instr[19:15]; rs1_used = 1'b1;
          end
        end
      end
      default: illegal = 1'b1;
    endcase

    if (rd == 5'd0) ctrl.reg_write = 1'b0;

    if (illegal) begin
      rd = '0; rs1 = '0; rs2 = '0;
      rs1_used = 1'b0; rs2_used = 1'b0;
      imm = '0; alu_op = ALU_ADD; ctrl = '0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage between fetch and execute, with a
// 2-entry skid buffer (main + skid) so execute back-pressure never loses beats.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 drop every buffered and incoming beat
//   in_valid/in_ready     fetch handshake; in_instr/in_pc carried with it
//   out_valid/out_ready   execute handshake; out_* fields carried with it
//   out_rd/rs1/rs2, out_rs1_used/out_rs2_used, out_imm, out_alu_op,
//   out_ctrl, out_illegal, out_pc   decoded beat
//   dbg_state             skid-buffer occupancy (buf_state_e)
//
// Handshake: a beat moves when valid && ready at a rising edge. A producer
// holds valid and its data until it is taken; out_* do not change while
// out_valid && !out_ready. in_ready depends only on registered state (low
// only when both entries are occupied), so there is no out_ready->in_ready path.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ENABLE_M   = 1,
  parameter int ENABLE_CSR = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_alu_op,
  output ctrl_t           out_ctrl,
  output logic            out_illegal,
  output logic [1:0]      dbg_state
);

  localparam int BEAT_W = 2 * XLEN + 3 * 5 + 2 + 5 + CTRL_W + 1;

  logic [4:0]      d_rd, d_rs1, d_rs2, d_alu_op;
  logic            d_rs1_used, d_rs2_used, d_illegal;
  logic [XLEN-1:0] d_imm;
  ctrl_t           d_ctrl;
  logic [BEAT_W-1:0] dec_beat;

  buf_state_e        state_q, state_d;
  logic [BEAT_W-1:0] main_q, main_d;
  logic [BEAT_W-1:0] skid_q, skid_d;
  logic              accept, pop;

  decode_comb #(
    .XLEN      (XLEN),
    .ENABLE_M  (ENABLE_M),
    .ENABLE_CSR(ENABLE_CSR)
  ) u_decode_comb (
    .instr   (in_instr),
    .rd      (d_rd),
    .rs1     (d_rs1),
    .rs2     (d_rs2),
    .rs1_used(d_rs1_used),
    .rs2_used(d_rs2_used),
    .imm     (d_imm),
    .alu_op  (d_alu_op),
    .ctrl    (d_ctrl),
    .illegal (d_illegal)
  );

  assign dec_beat = {in_pc, d_rd, d_rs1, d_rs2, d_rs1_used, d_rs2_used,
                     d_imm, d_alu_op, d_ctrl, d_illegal};

  assign in_ready  = (state_q != BUF_FULL);
  assign out_valid = (state_q != BUF_EMPTY);
  assign dbg_state = state_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign {out_pc, out_rd, out_rs1, out_rs2, out_rs1_used, out_rs2_used,
          out_imm, out_alu_op, out_ctrl, out_illegal} = main_q;

  // main_q always holds the oldest beat; skid_q only fills when a beat
  // arrives while main_q is stalled.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            main_d  = dec_beat;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && pop) begin
            main_d = dec_beat;
          end else if (accept) begin
            skid_d  = dec_beat;
            state_d = BUF_FULL;
          end else if (pop) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage (XLEN=32).
// A second instance with ENABLE_M=0 shares all inputs with the main one.
module tb_decode_stage;
  import decode_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  logic        in_ready, out_valid, out_rs1_used, out_rs2_used, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_alu_op;
  ctrl_t       out_ctrl;
  logic [1:0]  dbg_state;

  logic        n_in_ready, n_out_valid, n_rs1_used, n_rs2_used, n_illegal;
  logic [31:0] n_pc, n_imm;
  logic [4:0]  n_rd, n_rs1, n_rs2, n_alu_op;
  ctrl_t       n_ctrl;
  logic [1:0]  n_dbg_state;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .ENABLE_M(1), .ENABLE_CSR(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
    .out_imm(out_imm), .out_alu_op(out_alu_op), .out_ctrl(out_ctrl),
    .out_illegal(out_illegal), .dbg_state(dbg_state)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(0), .ENABLE_CSR(1)) dut_nom (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_pc),
    .out_rd(n_rd), .out_rs1(n_rs1), .out_rs2(n_rs2),
    .out_rs1_used(n_rs1_used), .out_rs2_used(n_rs2_used),
    .out_imm(n_imm), .out_alu_op(n_alu_op), .out_ctrl(n_ctrl),
    .out_illegal(n_illegal), .dbg_state(n_dbg_state)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference table ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic        ill;
    ctrl_t       ctrl;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        nom_ill;
    ctrl_t       nom_ctrl;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  localparam int NTAB = 20;
  localparam logic [31:0] TAB [0:NTAB-1] = '{
    32'hFFF08293, 32'h022081B3, 32'h02009093, 32'h00208033, 32'h30200073,
    32'h00000073, 32'h00100073, 32'h800003B7, 32'hFE208EE3, 32'h00002063,
    32'h0000007F, 32'h0020A423, 32'h0000B083, 32'h0262D233, 32'h403100B3,
    32'h40001033, 32'h008000EF, 32'h300312F3, 32'h3002E073, 32'h10500073
  };

  // Hand-derived decode results for every table entry.
  function automatic exp_t golden(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e = '0;
    e.pc = pc;
    case (instr)
      32'hFFF08293: begin // addi x5,x1,-1
        e.rd = 5; e.rs1 = 1; e.u1 = 1; e.imm = 32'hFFFF_FFFF; e.alu = 5'b01010;
        e.ctrl.reg_write = 1; e.ctrl.alu_src = 1;
      end
      32'h022081B3: begin // mul x3,x1,x2
        e.rd = 3; e.rs1 = 1; e.rs2 = 2; e.u1 = 1; e.u2 = 1; e.alu = 5'b10011;
        e.ctrl.reg_write = 1;
      end
      32'h00208033: begin // add x0,x1,x2
        e.rs1 = 1; e.rs2 = 2; e.u1 = 1; e.u2 = 1;
      end
      32'h30200073: e.ctrl.is_mret = 1;
      32'h00000073: e.ctrl.is_ecall = 1;
      32'h00100073: e.ctrl.is_ebreak = 1;
      32'h800003B7: begin // lui x7,0x80000
        e.rd = 7; e.imm = 32'h8000_0000;
        e.ctrl.reg_write = 1; e.ctrl.alu_src = 1; e.ctrl.is_lui = 1;
      end
      32'hFE208EE3: begin // beq x1,x2,-4
        e.rs1 = 1; e.rs2 = 2; e.u1 = 1; e.u2 = 1; e.imm = 32'hFFFF_FFFC;
        e.ctrl.is_branch = 1; e.ctrl.b_type = 3'b000;
      end
      32'h0020A423: begin // sw x2,8(x1)
        e.rs1 = 1; e.rs2 = 2; e.u1 = 1; e.u2 = 1; e.imm = 32'd8;
        e.ctrl.alu_src = 1; e.ctrl.is_store = 1; e.ctrl.mem_size = 3'b010;
      end
      32'h0262D233: begin // divu x4,x5,x6
        e.rd = 4; e.rs1 = 5; e.rs2 = 6; e.u1 = 1; e.u2 = 1;
        e.ctrl.reg_write = 1; e.ctrl.is_div = 1; e.ctrl.div_op = 3'b101;
      end
      32'h403100B3: begin // sub x1,x2,x3
        e.rd = 1; e.rs1 = 2; e.rs2 = 3; e.u1 = 1; e.u2 = 1; e.alu = 5'b00001;
        e.ctrl.reg_write = 1;
      end
      32'h008000EF: begin // jal x1,+8
        e.rd = 1; e.imm = 32'd8;
        e.ctrl.reg_write = 1; e.ctrl.jal = 1;
      end
      32'h300312F3: begin // csrrw x5,mstatus,x6
        e.rd = 5; e.rs1 = 6; e.u1 = 1;
        e.ctrl.reg_write = 1; e.ctrl.csr_we = 1; e.ctrl.csr_func = 3'b001;
        e.ctrl.csr_addr = 12'h300;
      end
      32'h3002E073: begin // csrrsi x0,mstatus,5
        e.imm = 32'd5;
        e.ctrl.csr_we = 1; e.ctrl.csr_func = 3'b110; e.ctrl.csr_addr = 12'h300;
      end
      // slli with bit25, branch f3=010, unknown opcode, ld on RV32,
      // funct7=0100000 with sll, system imm 0x105
      default: e.ill = 1;
    endcase
    e.nom_ill  = e.ill;
    e.nom_ctrl = e.ctrl;
    if (instr == 32'h022081B3 || instr == 32'h0262D233) begin
      e.nom_ill  = 1;
      e.nom_ctrl = '0;
    end
    return e;
  endfunction

  // ---------------- scoreboard: compare on every pop ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready && !flush) begin
      check("q_nonempty", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_t'(exp_q.pop_front());
        check("pc",       64'(out_pc),       64'(e.pc));
        check("illegal",  64'(out_illegal),  64'(e.ill));
        check("ctrl",     64'(out_ctrl),     64'(e.ctrl));
        check("alu_op",   64'(out_alu_op),   64'(e.alu));
        check("imm",      64'(out_imm),      64'(e.imm));
        check("rd",       64'(out_rd),       64'(e.rd));
        check("rs1",      64'(out_rs1),      64'(e.rs1));
        check("rs2",      64'(out_rs2),      64'(e.rs2));
        check("rs1_used", 64'(out_rs1_used), 64'(e.u1));
        check("rs2_used", 64'(out_rs2_used), 64'(e.u2));
        check("nom_valid",   64'(n_out_valid), 64'(1));
        check("nom_illegal", 64'(n_illegal),   64'(e.nom_ill));
        check("nom_ctrl",    64'(n_ctrl),      64'(e.nom_ctrl));
      end
    end
  end

  // ---------------- drivers ----------------
  logic rnd_ready = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Offer one beat and hold it until taken; expectation queued on acceptance.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    int waited;
    waited = 0;
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        exp_q.push_back(EXP_W'(golden(instr, pc)));
        @(posedge clk); #1;
        break;
      end
      waited++;
      if (waited > 100) begin
        check("send_timeout", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_state",     64'(dbg_state), 64'(BUF_EMPTY));
    check("rst_pc",        64'(out_pc),    64'(0));
    check("rst_imm",       64'(out_imm),   64'(0));
    check("rst_ctrl",      64'(out_ctrl),  64'(0));
    check("rst_rd",        64'(out_rd),    64'(0));
    check("rst_illegal",   64'(out_illegal), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // single-cycle latency with an empty buffer
    send(32'hFFF08293, 32'h100);
    @(negedge clk);
    check("latency_valid", 64'(out_valid), 64'(1));
    check("latency_rd",    64'(out_rd),    64'(5));
    @(posedge clk); #1;

    // every table entry back to back
    for (int i = 0; i < NTAB; i++) send(TAB[i], 32'h200 + 32'(4 * i));
    drain();

    // back-pressure: two accepted, third stalls, outputs stable
    out_ready = 1'b0;
    send(32'hFFF08293, 32'h300);
    send(32'h403100B3, 32'h304);
    in_instr = 32'h008000EF;
    in_pc    = 32'h308;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready",  64'(in_ready),  64'(0));
      check("bp_state",     64'(dbg_state), 64'(BUF_FULL));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_out_pc",    64'(out_pc),    64'(32'h300));
      check("bp_out_rd",    64'(out_rd),    64'(5));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h008000EF, 32'h308);
    drain();

    // flush while FULL with a beat offered in the same cycle
    out_ready = 1'b0;
    send(32'hFFF08293, 32'h400);
    send(32'h022081B3, 32'h404);
    in_instr = 32'h800003B7;
    in_pc    = 32'hDEAD0;
    in_valid = 1'b1;
    flush    = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_in_ready",  64'(in_ready),  64'(1));
    check("flush_state",     64'(dbg_state), 64'(BUF_EMPTY));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_no_ghost", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;

    // flush wins over a simultaneous pop
    send(32'h403100B3, 32'h500);
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_pop_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    send(32'hFFF08293, 32'h600);
    send(32'h008000EF, 32'h604);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_in_ready",  64'(in_ready),  64'(1));
    check("arst_out_pc",    64'(out_pc),    64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // random stream under random back-pressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      send(TAB[$urandom_range(0, NTAB - 1)], 32'h1000 + 32'(4 * i));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
